// File: rtl/axi_mem_responder_pkg.sv
// rtl/axi_mem_responder_pkg.sv - shared response codes, FSM encodings and log2 helper
package axi_mem_responder_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  // Ceiling log2, usable in constant expressions.
  function automatic int c_log_2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_resp_ram.sv
// rtl/axi_resp_ram.sv - dual-port RAM, byte-enable write, registered read-first read
module axi_resp_ram #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [DATA_W/8-1:0]   wstrb_i,
  input  logic                  re_i,
  input  logic [ADDR_W-1:0]     raddr_i,
  output logic [DATA_W-1:0]     rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Byte-lane write; the array is never reset so contents survive a reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (wstrb_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  // Output register only updates on a read request, so data holds during stalls;
  // a same-edge write to the same word is not visible (read-first).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_mem_responder.sv
// rtl/axi_mem_responder.sv - AXI3-style slave memory model with independent read/write FSMs
module axi_mem_responder
  import axi_mem_responder_pkg::*;
#(
  parameter int AXI_TID_WIDTH = 6,
  parameter int ADDR_W        = 32,
  parameter int AXI_DATA_W    = 64,
  parameter int MEM_ADDR_W    = 10,
  localparam int AXI_WSTRB_W  = AXI_DATA_W / 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [AXI_TID_WIDTH-1:0] S_AXI_AWID,
  input  logic [ADDR_W-1:0]        S_AXI_AWADDR,
  input  logic [3:0]               S_AXI_AWLEN,
  input  logic                     S_AXI_AWVALID,
  output logic                     S_AXI_AWREADY,
  input  logic [AXI_DATA_W-1:0]    S_AXI_WDATA,
  input  logic [AXI_WSTRB_W-1:0]   S_AXI_WSTRB,
  input  logic                     S_AXI_WLAST,
  input  logic                     S_AXI_WVALID,
  output logic                     S_AXI_WREADY,
  output logic [AXI_TID_WIDTH-1:0] S_AXI_BID,
  output logic [1:0]               S_AXI_BRESP,
  output logic                     S_AXI_BVALID,
  input  logic                     S_AXI_BREADY,
  input  logic [AXI_TID_WIDTH-1:0] S_AXI_ARID,
  input  logic [ADDR_W-1:0]        S_AXI_ARADDR,
  input  logic [3:0]               S_AXI_ARLEN,
  input  logic                     S_AXI_ARVALID,
  output logic                     S_AXI_ARREADY,
  output logic [AXI_TID_WIDTH-1:0] S_AXI_RID,
  output logic [AXI_DATA_W-1:0]    S_AXI_RDATA,
  output logic [1:0]               S_AXI_RRESP,
  output logic                     S_AXI_RLAST,
  output logic                     S_AXI_RVALID,
  input  logic                     S_AXI_RREADY
);

  localparam int BYTE_OFF = c_log_2(AXI_WSTRB_W);

  // Address bits outside the word index are ignored by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{S_AXI_AWADDR, S_AXI_ARADDR};

  // ---------------- write channel state ----------------
  w_state_e                 w_state_q, w_state_d;
  logic [AXI_TID_WIDTH-1:0] w_id_q,    w_id_d;
  logic [MEM_ADDR_W-1:0]    w_addr_q,  w_addr_d;
  logic [3:0]               w_len_q,   w_len_d;
  logic [3:0]               w_beat_q,  w_beat_d;
  logic                     w_err_q,   w_err_d;
  logic                     awready_q, awready_d;
  logic                     ram_we;

  // ---------------- read channel state ----------------
  r_state_e                 r_state_q, r_state_d;
  logic [AXI_TID_WIDTH-1:0] r_id_q,    r_id_d;
  logic [MEM_ADDR_W-1:0]    r_addr_q,  r_addr_d;
  logic [3:0]               r_len_q,   r_len_d;
  logic [3:0]               r_beat_q,  r_beat_d;
  logic                     arready_q, arready_d;
  logic                     ram_re;
  logic [MEM_ADDR_W-1:0]    ram_raddr;
  logic [AXI_DATA_W-1:0]    ram_rdata;

  // Write FSM next state: the burst ends on beat len whatever WLAST says; a misplaced
  // or missing WLAST only sets the sticky error reported in BRESP.
  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_addr_d  = w_addr_q;
    w_len_d   = w_len_q;
    w_beat_d  = w_beat_q;
    w_err_d   = w_err_q;
    ram_we    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (S_AXI_AWVALID && awready_q) begin
          w_id_d    = S_AXI_AWID;
          w_addr_d  = S_AXI_AWADDR[MEM_ADDR_W+BYTE_OFF-1:BYTE_OFF];
          w_len_d   = S_AXI_AWLEN;
          w_beat_d  = 4'd0;
          w_err_d   = 1'b0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (S_AXI_WVALID) begin
          ram_we   = 1'b1;
          w_addr_d = w_addr_q + 1'b1;
          w_beat_d = w_beat_q + 1'b1;
          if (S_AXI_WLAST != (w_beat_q == w_len_q)) w_err_d = 1'b1;
          if (w_beat_q == w_len_q) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE);
  end

  // Write FSM registers; AWREADY is registered so it stays low through reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_beat_q  <= '0;
      w_err_q   <= 1'b0;
      awready_q <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_beat_q  <= w_beat_d;
      w_err_q   <= w_err_d;
      awready_q <= awready_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = (w_state_q == W_DATA);
  assign S_AXI_BVALID  = (w_state_q == W_RESP);
  assign S_AXI_BID     = w_id_q;
  assign S_AXI_BRESP   = (S_AXI_BVALID && w_err_q) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;

  // Read FSM next state: r_addr_q always points at the next word to fetch, and a
  // fetch is issued on AR acceptance and on every non-final R handshake, which
  // keeps one beat per cycle while the RAM output register holds during stalls.
  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_beat_d  = r_beat_q;
    ram_re    = 1'b0;
    ram_raddr = r_addr_q;
    case (r_state_q)
      R_IDLE: begin
        if (S_AXI_ARVALID && arready_q) begin
          ram_re    = 1'b1;
          ram_raddr = S_AXI_ARADDR[MEM_ADDR_W+BYTE_OFF-1:BYTE_OFF];
          r_addr_d  = S_AXI_ARADDR[MEM_ADDR_W+BYTE_OFF-1:BYTE_OFF] + 1'b1;
          r_id_d    = S_AXI_ARID;
          r_len_d   = S_AXI_ARLEN;
          r_beat_d  = 4'd0;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          if (r_beat_q == r_len_q) begin
            r_state_d = R_IDLE;
          end else begin
            ram_re   = 1'b1;
            r_addr_d = r_addr_q + 1'b1;
            r_beat_d = r_beat_q + 1'b1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
  end

  // Read FSM registers; ARREADY is registered so it stays low through reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_beat_q  <= '0;
      arready_q <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_beat_q  <= r_beat_d;
      arready_q <= arready_d;
    end
  end

  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = (r_state_q == R_DATA);
  assign S_AXI_RLAST   = S_AXI_RVALID && (r_beat_q == r_len_q);
  assign S_AXI_RID     = r_id_q;
  assign S_AXI_RRESP   = AXI_RESP_OKAY;
  assign S_AXI_RDATA   = ram_rdata;

  axi_resp_ram #(
    .DATA_W (AXI_DATA_W),
    .ADDR_W (MEM_ADDR_W)
  ) u_ram (
    .clk_i   (clk),
    .rst_i   (reset),
    .we_i    (ram_we),
    .waddr_i (w_addr_q),
    .wdata_i (S_AXI_WDATA),
    .wstrb_i (S_AXI_WSTRB),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_axi_mem_responder.sv
// tb/tb_axi_mem_responder.sv - scoreboard bench for axi_mem_responder
module tb_axi_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  S_AXI_AWID;
  logic [31:0] S_AXI_AWADDR;
  logic [3:0]  S_AXI_AWLEN;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [63:0] S_AXI_WDATA;
  logic [7:0]  S_AXI_WSTRB;
  logic        S_AXI_WLAST;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [5:0]  S_AXI_BID;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [5:0]  S_AXI_ARID;
  logic [31:0] S_AXI_ARADDR;
  logic [3:0]  S_AXI_ARLEN;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [5:0]  S_AXI_RID;
  logic [63:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RLAST;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;

  axi_mem_responder dut (
    .clk           (clk),
    .reset         (reset),
    .S_AXI_AWID    (S_AXI_AWID),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWLEN   (S_AXI_AWLEN),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WLAST   (S_AXI_WLAST),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BID     (S_AXI_BID),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARID    (S_AXI_ARID),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARLEN   (S_AXI_ARLEN),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RID     (S_AXI_RID),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RLAST   (S_AXI_RLAST),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] id;
    logic [1:0] resp;
  } b_exp_t;

  typedef struct {
    logic [5:0]  id;
    logic [63:0] data;
    logic        last;
  } r_exp_t;

  b_exp_t      bq[$];
  r_exp_t      rq[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          r_hs = 0;
  bit          r_mon_en = 1'b1;
  bit          r_toggle = 1'b0;
  logic [63:0] wbuf[16];
  logic [63:0] rexp[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic flag(input string name, input string what);
    vectors++;
    miscompares++;
    $display("FAIL %s: %s", name, what);
  endtask

  // B monitor: pop and compare on every accepted write response.
  always @(negedge clk) begin
    if (!reset && S_AXI_BVALID && S_AXI_BREADY) begin
      if (bq.size() == 0) begin
        flag("b_unexpected", "response with nothing expected");
      end else begin
        b_exp_t e;
        e = bq.pop_front();
        chk("bid", 64'(S_AXI_BID), 64'(e.id));
        chk("bresp", 64'(S_AXI_BRESP), 64'(e.resp));
      end
    end
  end

  // R monitor: compare accepted beats and check stability across stalls.
  logic        hold_pend = 1'b0;
  logic [63:0] hold_data;
  logic        hold_last;
  logic [5:0]  hold_id;
  always @(negedge clk) begin
    if (reset || !r_mon_en) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("rvalid_hold", 64'(S_AXI_RVALID), 64'd1);
        chk("rdata_hold", S_AXI_RDATA, hold_data);
        chk("rlast_rid_hold", 64'({S_AXI_RLAST, S_AXI_RID}), 64'({hold_last, hold_id}));
        hold_pend = 1'b0;
      end
      if (S_AXI_RVALID && S_AXI_RREADY) begin
        r_hs++;
        if (rq.size() == 0) begin
          flag("r_unexpected", "beat with nothing expected");
        end else begin
          r_exp_t e;
          e = rq.pop_front();
          chk("rdata", S_AXI_RDATA, e.data);
          chk("rlast", 64'(S_AXI_RLAST), 64'(e.last));
          chk("rid", 64'(S_AXI_RID), 64'(e.id));
        end
      end else if (S_AXI_RVALID) begin
        hold_pend = 1'b1;
        hold_data = S_AXI_RDATA;
        hold_last = S_AXI_RLAST;
        hold_id   = S_AXI_RID;
      end
    end
  end

  // RREADY driver: held high, or toggled every cycle in stall mode.
  initial begin
    S_AXI_RREADY = 1'b1;
    forever begin
      @(posedge clk);
      #1 S_AXI_RREADY = r_toggle ? ~S_AXI_RREADY : 1'b1;
    end
  end

  task automatic do_write(input logic [5:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [7:0] strb, input int last_at, input logic [1:0] resp);
    int c;
    b_exp_t e;
    e.id = id;
    e.resp = resp;
    bq.push_back(e);
    S_AXI_AWID = id;
    S_AXI_AWADDR = addr;
    S_AXI_AWLEN = len;
    S_AXI_AWVALID = 1'b1;
    c = 0;
    do begin @(negedge clk); c++; end while (!S_AXI_AWREADY && c < 100);
    if (!S_AXI_AWREADY) flag("aw_timeout", "AWREADY never rose");
    @(posedge clk);
    #1 S_AXI_AWVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      S_AXI_WDATA = wbuf[i];
      S_AXI_WSTRB = strb;
      S_AXI_WLAST = (i == last_at);
      S_AXI_WVALID = 1'b1;
      c = 0;
      do begin @(negedge clk); c++; end while (!S_AXI_WREADY && c < 100);
      if (!S_AXI_WREADY) flag("w_timeout", "WREADY never rose");
      @(posedge clk);
      #1;
    end
    S_AXI_WVALID = 1'b0;
    S_AXI_WLAST = 1'b0;
    @(negedge clk);
    chk("bvalid_latency", 64'(S_AXI_BVALID), 64'd1);
    c = 0;
    do begin @(posedge clk); c++; end while (bq.size() > 0 && c < 100);
    if (bq.size() > 0) begin
      flag("b_timeout", "write response not seen");
      bq.delete();
    end
    #1;
  endtask

  task automatic do_read(input logic [5:0] id, input logic [31:0] addr, input logic [3:0] len);
    int c;
    int hs0;
    r_exp_t e;
    for (int i = 0; i <= int'(len); i++) begin
      e.id = id;
      e.data = rexp[i];
      e.last = (i == int'(len));
      rq.push_back(e);
    end
    hs0 = r_hs;
    S_AXI_ARID = id;
    S_AXI_ARADDR = addr;
    S_AXI_ARLEN = len;
    S_AXI_ARVALID = 1'b1;
    c = 0;
    do begin @(negedge clk); c++; end while (!S_AXI_ARREADY && c < 100);
    if (!S_AXI_ARREADY) flag("ar_timeout", "ARREADY never rose");
    @(posedge clk);
    #1 S_AXI_ARVALID = 1'b0;
    @(negedge clk);
    chk("rvalid_latency", 64'(S_AXI_RVALID), 64'd1);
    c = 0;
    do begin @(posedge clk); c++; end while (rq.size() > 0 && c < 200);
    if (rq.size() > 0) begin
      flag("r_timeout", "read beats missing");
      rq.delete();
    end else if (!r_toggle && len > 0) begin
      chk("read_full_rate_cycles", 64'(c), 64'(int'(len) + 1));
    end
    #1;
    chk("read_hs_count", 64'(r_hs - hs0), 64'(int'(len) + 1));
    @(negedge clk);
    chk("rvalid_drop", 64'(S_AXI_RVALID), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    S_AXI_AWID = '0; S_AXI_AWADDR = '0; S_AXI_AWLEN = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WLAST = 1'b0; S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b1;
    S_AXI_ARID = '0; S_AXI_ARADDR = '0; S_AXI_ARLEN = '0; S_AXI_ARVALID = 1'b0;

    // Reset state and ready rise after release.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_flags", 64'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RLAST}), 64'd0);
    chk("reset_rdata", S_AXI_RDATA, 64'd0);
    chk("reset_ids_resps", 64'({S_AXI_BID, S_AXI_RID, S_AXI_BRESP, S_AXI_RRESP}), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("ready_before_edge", 64'({S_AXI_AWREADY, S_AXI_ARREADY}), 64'd0);
    @(negedge clk);
    chk("ready_after_edge", 64'({S_AXI_AWREADY, S_AXI_ARREADY}), 64'b11);
    @(posedge clk);
    #1;

    // Basic 4-beat write then readback.
    wbuf[0] = 64'h11; wbuf[1] = 64'h22; wbuf[2] = 64'h33; wbuf[3] = 64'h44;
    do_write(6'd5, 32'h40, 4'd3, 8'hFF, 3, 2'b00);
    rexp[0] = 64'h11; rexp[1] = 64'h22; rexp[2] = 64'h33; rexp[3] = 64'h44;
    do_read(6'd5, 32'h40, 4'd3);

    // Byte strobes: all-ones word, clear low four bytes.
    wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    do_write(6'd1, 32'h100, 4'd0, 8'hFF, 0, 2'b00);
    wbuf[0] = 64'h0;
    do_write(6'd2, 32'h100, 4'd0, 8'h0F, 0, 2'b00);
    rexp[0] = 64'hFFFF_FFFF_0000_0000;
    do_read(6'd3, 32'h100, 4'd0);

    // 16-beat burst read back with RREADY toggling.
    for (int i = 0; i < 16; i++) begin
      wbuf[i] = 64'hA5A5_0000_0000_0100 + 64'(i);
      rexp[i] = 64'hA5A5_0000_0000_0100 + 64'(i);
    end
    do_write(6'd7, 32'h200, 4'd15, 8'hFF, 15, 2'b00);
    r_toggle = 1'b1;
    do_read(6'd9, 32'h200, 4'd15);
    r_toggle = 1'b0;
    @(posedge clk);
    #1;

    // Misplaced WLAST gives SLVERR; a clean burst afterwards gives OKAY.
    wbuf[0] = 64'hC0; wbuf[1] = 64'hC1; wbuf[2] = 64'hC2; wbuf[3] = 64'hC3;
    do_write(6'd4, 32'h300, 4'd3, 8'hFF, 1, 2'b10);
    do_write(6'd4, 32'h300, 4'd3, 8'hFF, 3, 2'b00);

    // Address wrap at the top of the RAM.
    wbuf[0] = 64'hD0; wbuf[1] = 64'hD1; wbuf[2] = 64'hD2; wbuf[3] = 64'hD3;
    do_write(6'd6, 32'd8176, 4'd3, 8'hFF, 3, 2'b00);
    rexp[0] = 64'hD2; rexp[1] = 64'hD3;
    do_read(6'd6, 32'h0, 4'd1);

    // Reset in the middle of an 8-beat read.
    r_mon_en = 1'b0;
    S_AXI_ARID = 6'd2; S_AXI_ARADDR = 32'h200; S_AXI_ARLEN = 4'd7; S_AXI_ARVALID = 1'b1;
    begin
      int c;
      c = 0;
      do begin @(negedge clk); c++; end while (!S_AXI_ARREADY && c < 100);
      if (!S_AXI_ARREADY) flag("ar_timeout_rst", "ARREADY never rose");
    end
    @(posedge clk);
    #1 S_AXI_ARVALID = 1'b0;
    repeat (3) @(negedge clk);
    chk("rvalid_mid_burst", 64'(S_AXI_RVALID), 64'd1);
    reset = 1'b1;
    #1;
    chk("rvalid_async_drop", 64'(S_AXI_RVALID), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    r_mon_en = 1'b1;
    @(negedge clk);
    chk("arready_before_edge_rst", 64'(S_AXI_ARREADY), 64'd0);
    @(negedge clk);
    chk("arready_after_rst", 64'({S_AXI_ARREADY, S_AXI_RVALID}), 64'b10);
    @(posedge clk);
    #1;
    rexp[0] = 64'h11; rexp[1] = 64'h22; rexp[2] = 64'h33; rexp[3] = 64'h44;
    do_read(6'd5, 32'h40, 4'd3);
    rexp[0] = 64'hD0; rexp[1] = 64'hD1;
    do_read(6'd8, 32'd8176, 4'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
